// File: rtl/fpga_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fpga_io_pkg
//  Purpose  : Shared bit positions and constants for the DE1-SoC input
//             front-end (push-buttons and slide switches).
//  Revision : 1.0  initial release
// ============================================================================
package fpga_io_pkg;

    // Push-button roles (KEY bus, active-low)
    localparam int KEY_STEP      = 0;
    localparam int KEY_CPU_RST   = 1;

    // Slide-switch fields
    localparam int SW_MANUAL_CLK = 9;
    localparam int SW_SHOW_REG   = 8;
    localparam int SW_STAGE_LSB  = 0;
    localparam int SW_REG_LSB    = 4;

    // Idle level of a push-button
    localparam logic RELEASED    = 1'b1;

    // Bus widths
    localparam int N_KEYS        = 4;
    localparam int N_SW          = 10;

endpackage : fpga_io_pkg
`default_nettype wire

// File: rtl/fpga_input_conditioner_debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_bit
//  Purpose  : One input bit: SYNC_STAGES-deep synchroniser followed by a
//             counter debouncer that accepts a new level only after it has
//             differed from the stable level for DEBOUNCE_CYCLES cycles.
//  Revision : 1.0  initial release
// ============================================================================
module debounce_bit
    import fpga_io_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 500000,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_raw,
    output logic q
);

    // A one-cycle debouncer still needs a one-bit counter to stay legal
    localparam int                 c_CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_stable;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign q        = r_stable;

    // Synchroniser chain; resets to the idle level so no false edge appears
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            r_sync[0] <= d_raw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    // Debounce counter: any return to the stable level restarts the count,
    // and the count never exceeds c_CNT_MAX because it clears on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stable <= RESET_VAL;
            r_cnt    <= '0;
        end else if (w_synced == r_stable) begin
            r_cnt    <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
            r_stable <= w_synced;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule : debounce_bit
`default_nettype wire

// File: rtl/fpga_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : fpga_input_conditioner
//  Purpose  : Synchronise/debounce DE1-SoC KEY and SW inputs, generate the
//             pipeline step enable (manual KEY0 press or auto divider), the
//             registered cpu_rst and the sw_changed pulse.
//  Revision : 1.0  initial release
// ============================================================================
module fpga_input_conditioner
    import fpga_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2,
    parameter int AUTO_DIV        = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  KEY,
    input  logic [9:0]  SW_raw,
    output logic [9:0]  SW,
    output logic        step_en,
    output logic        cpu_rst,
    output logic        sw_changed
);

    localparam int                 c_DIV_W   = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_MAX = c_DIV_W'(AUTO_DIV - 1);

    logic [N_KEYS-1:0]  w_key_db;
    logic [N_SW-1:0]    w_sw_db;
    logic [N_SW-1:0]    r_sw_prev;
    logic               r_key0_prev;
    logic [c_DIV_W-1:0] r_div;
    logic               r_step;
    logic               r_cpu_rst;
    logic               r_sw_changed;

    logic               w_mode_chg;
    logic               w_press;
    logic               w_div_wrap;
    logic               w_step_req;
    logic               w_cpu_rst_req;
    logic               w_unused_keys;

    // KEY[3:2] are conditioned for future use
    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_key
            debounce_bit #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_VAL       (RELEASED)
            ) u_db (
                .clk   (clk),
                .rst   (rst),
                .d_raw (KEY[gi]),
                .q     (w_key_db[gi])
            );
        end
        for (gi = 0; gi < N_SW; gi++) begin : g_sw
            debounce_bit #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_VAL       (1'b0)
            ) u_db (
                .clk   (clk),
                .rst   (rst),
                .d_raw (SW_raw[gi]),
                .q     (w_sw_db[gi])
            );
        end
    endgenerate

    assign w_unused_keys = ^w_key_db[3:2];

    // A mode flip restarts the divider and swallows any coincident KEY0 edge
    assign w_mode_chg    = (w_sw_db[SW_MANUAL_CLK] != r_sw_prev[SW_MANUAL_CLK]);
    assign w_press       = (r_key0_prev == RELEASED) && (w_key_db[KEY_STEP] != RELEASED);
    assign w_div_wrap    = (r_div == c_DIV_MAX);
    assign w_step_req    = !w_mode_chg &&
                           (w_sw_db[SW_MANUAL_CLK] ? w_press : w_div_wrap);
    assign w_cpu_rst_req = rst || (w_key_db[KEY_CPU_RST] != RELEASED);

    assign SW         = w_sw_db;
    assign step_en    = r_step;
    assign cpu_rst    = r_cpu_rst;
    assign sw_changed = r_sw_changed;

    // Edge detect, auto divider, cpu_rst and sw_changed registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_prev    <= '0;
            r_key0_prev  <= RELEASED;
            r_div        <= '0;
            r_step       <= 1'b0;
            r_cpu_rst    <= 1'b1;
            r_sw_changed <= 1'b0;
        end else begin
            r_sw_prev    <= w_sw_db;
            r_key0_prev  <= w_key_db[KEY_STEP];
            r_sw_changed <= (w_sw_db != r_sw_prev);
            r_cpu_rst    <= w_cpu_rst_req;
            // step_en shares the cpu_rst timing so the two are never both high
            r_step       <= w_step_req && !w_cpu_rst_req;
            if (w_mode_chg || w_div_wrap) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

endmodule : fpga_input_conditioner
`default_nettype wire

// File: tb/tb_fpga_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpga_input_conditioner
//  Purpose  : Self-checking bench; expected step_en / sw_changed events are
//             queued with the stimulus and popped as the DUT produces them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fpga_input_conditioner;

    localparam int DB = 4;
    localparam int AD = 8;
    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] KEY;
    logic [9:0] SW_raw;
    logic [9:0] SW;
    logic       step_en;
    logic       cpu_rst;
    logic       sw_changed;

    fpga_input_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .SYNC_STAGES     (SS),
        .AUTO_DIV        (AD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .KEY        (KEY),
        .SW_raw     (SW_raw),
        .SW         (SW),
        .step_en    (step_en),
        .cpu_rst    (cpu_rst),
        .sw_changed (sw_changed)
    );

    always #5 clk = ~clk;

    // Number of rising edges seen so far
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, got, got, exp, exp, cyc);
        end
    endtask

    typedef struct {
        int cyc;
        int sw;
    } sw_ev_t;

    int     step_q[$];
    sw_ev_t sw_q[$];
    int     step_seen = 0;
    int     e_step;
    sw_ev_t e_sw;

    // Scoreboard side: every observed pulse must match the next queued event
    always @(negedge clk) begin
        if (step_en === 1'b1) begin
            step_seen++;
            if (step_q.size() == 0) begin
                check_eq("step_unexpected", int'(step_en), 0);
            end else begin
                e_step = step_q.pop_front();
                check_eq("step_cycle", cyc, e_step);
            end
        end
        if (sw_changed === 1'b1) begin
            if (sw_q.size() == 0) begin
                check_eq("swchg_unexpected", int'(sw_changed), 0);
            end else begin
                e_sw = sw_q.pop_front();
                check_eq("swchg_cycle", cyc, e_sw.cyc);
                check_eq("swchg_SW", int'(SW), e_sw.sw);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n0;
        int m;
        int base;

        // Reset state
        rst    = 1'b1;
        KEY    = 4'hF;
        SW_raw = 10'h200;
        tick(2);
        check_eq("rst_SW", int'(SW), 0);
        check_eq("rst_step_en", int'(step_en), 0);
        check_eq("rst_sw_changed", int'(sw_changed), 0);
        check_eq("rst_cpu_rst", int'(cpu_rst), 1);
        rst = 1'b0;
        n0  = cyc;
        sw_q.push_back('{cyc: n0 + SS + DB + 1, sw: 32'h200});
        tick_to(n0 + 1);
        check_eq("cpu_rst_release", int'(cpu_rst), 0);
        tick_to(n0 + SS + DB - 1);
        check_eq("SW_latency_early", int'(SW), 0);
        tick_to(n0 + SS + DB);
        check_eq("SW_latency", int'(SW), 32'h200);
        tick(6);

        // Glitch of exactly DB-1 synced cycles in manual mode
        base = step_seen;
        KEY  = 4'hE;
        tick(3);
        KEY  = 4'hF;
        tick(20);
        check_eq("glitch_steps", step_seen - base, 0);

        // Clean press: one pulse SS+DB+1 edges after the drop, none on release
        base = step_seen;
        KEY  = 4'hE;
        n0   = cyc;
        step_q.push_back(n0 + SS + DB + 1);
        tick(12);
        KEY  = 4'hF;
        tick(15);
        check_eq("press_steps", step_seen - base, 1);

        // rst pulsed part-way through a KEY0 press: count restarts, no step
        base = step_seen;
        KEY  = 4'hE;
        tick(2);
        rst  = 1'b1;
        tick(1);
        rst  = 1'b0;
        n0   = cyc;
        check_eq("midrst_SW", int'(SW), 0);
        check_eq("midrst_cpu_rst", int'(cpu_rst), 1);
        sw_q.push_back('{cyc: n0 + SS + DB + 1, sw: 32'h200});
        tick_to(n0 + SS + DB - 1);
        check_eq("midrst_SW_early", int'(SW), 0);
        tick_to(n0 + SS + DB);
        check_eq("midrst_SW_restart", int'(SW), 32'h200);
        tick(10);
        KEY  = 4'hF;
        tick(12);
        check_eq("midrst_steps", step_seen - base, 0);

        // Switch field change
        SW_raw = 10'h210;
        n0     = cyc;
        sw_q.push_back('{cyc: n0 + SS + DB + 1, sw: 32'h210});
        tick_to(n0 + SS + DB - 1);
        check_eq("swfield_early", int'(SW), 32'h200);
        tick_to(n0 + SS + DB);
        check_eq("swfield_SW", int'(SW), 32'h210);
        tick(8);

        // Auto mode: first step AD edges after the registered mode change,
        // KEY0 ignored, KEY1 hold blocks steps while cpu_rst is high
        SW_raw = 10'h010;
        n0     = cyc;
        m      = n0 + 40;
        sw_q.push_back('{cyc: n0 + SS + DB + 1, sw: 32'h010});
        for (int t = n0 + SS + DB + 1 + AD; t <= n0 + 79; t += AD) begin
            if (t < m + SS + DB + 1 || t > m + 10 + SS + DB) begin
                step_q.push_back(t);
            end
        end
        tick_to(n0 + 20);
        KEY = 4'hE;
        tick(12);
        KEY = 4'hF;
        check_eq("auto_SW", int'(SW), 32'h010);
        tick_to(m);
        KEY = 4'hD;
        tick_to(m + SS + DB);
        check_eq("cpurst_before", int'(cpu_rst), 0);
        tick_to(m + SS + DB + 1);
        check_eq("cpurst_rise", int'(cpu_rst), 1);
        tick_to(m + 10);
        KEY = 4'hF;
        tick_to(m + 10 + SS + DB);
        check_eq("cpurst_hold_end", int'(cpu_rst), 1);
        tick_to(m + 10 + SS + DB + 1);
        check_eq("cpurst_fall", int'(cpu_rst), 0);
        tick_to(n0 + 82);

        check_eq("step_queue_left", step_q.size(), 0);
        check_eq("swchg_queue_left", sw_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_fpga_input_conditioner
`default_nettype wire
